// File: rtl/hough_pkg.sv
// Shared widths, node word layout and walker state encoding for the
// Hough linked-list builder/walker pair.
package hough_pkg;

  localparam int THETA_W   = 8;
  localparam int PTR_W     = 12;
  localparam int PAYLOAD_W = 20;
  localparam int NODE_W    = 32;

  localparam logic [PTR_W-1:0] NULL_PTR = 12'h000;

  localparam int NEXT_MSB    = 31;
  localparam int NEXT_LSB    = 20;
  localparam int PAYLOAD_MSB = 19;
  localparam int PAYLOAD_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_HEAD,
    S_WAIT_HEAD,
    S_RD_NODE,
    S_WAIT_NODE,
    S_EMIT,
    S_DONE
  } walk_state_e;

endpackage

// File: rtl/hough_list_walker_if.sv
// Control, list-memory and payload-stream signals of the list walker.
interface hough_list_walker_if;
  import hough_pkg::*;

  logic                 start_i;
  logic [THETA_W-1:0]   theta_i;
  logic                 busy_o;
  logic                 done_o;
  logic [PTR_W-1:0]     count_o;
  logic                 err_theta_o;
  logic                 err_loop_o;
  logic                 head_rd_o;
  logic [THETA_W-1:0]   head_addr_o;
  logic [PTR_W-1:0]     head_data_i;
  logic                 node_rd_o;
  logic [PTR_W-1:0]     node_addr_o;
  logic [NODE_W-1:0]    node_data_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [PAYLOAD_W-1:0] out_data_o;
  logic                 out_last_o;

  modport master (
    input  start_i, theta_i, head_data_i, node_data_i, out_ready_i,
    output busy_o, done_o, count_o, err_theta_o, err_loop_o,
    output head_rd_o, head_addr_o, node_rd_o, node_addr_o,
    output out_valid_o, out_data_o, out_last_o
  );

  modport slave (
    output start_i, theta_i, head_data_i, node_data_i, out_ready_i,
    input  busy_o, done_o, count_o, err_theta_o, err_loop_o,
    input  head_rd_o, head_addr_o, node_rd_o, node_addr_o,
    input  out_valid_o, out_data_o, out_last_o
  );

endinterface

// File: rtl/hough_list_walker.sv
// Walks one theta bin's linked list: head table lookup, then node RAM
// chain, streaming each payload with a last flag and a loop guard.
module hough_list_walker
  import hough_pkg::*;
#(
  parameter int THETA_BINS = 180,
  parameter int MAX_NODES  = 4095
) (
  input logic               clk,
  input logic               rst,
  hough_list_walker_if.master bus
);

  localparam logic [PTR_W-1:0] LAST_CNT = PTR_W'(MAX_NODES - 1);

  walk_state_e          state_q, state_d;
  logic [PTR_W-1:0]     count_q, count_d;
  logic                 err_theta_q, err_theta_d;
  logic                 err_loop_q, err_loop_d;
  logic                 head_rd_q, head_rd_d;
  logic [THETA_W-1:0]   head_addr_q, head_addr_d;
  logic                 node_rd_q, node_rd_d;
  logic [PTR_W-1:0]     node_addr_q, node_addr_d;
  logic [PTR_W-1:0]     next_q, next_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 last;

  assign last = (next_q == NULL_PTR) || (count_q == LAST_CNT);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    err_theta_d = err_theta_q;
    err_loop_d  = err_loop_q;
    head_rd_d   = 1'b0;
    head_addr_d = head_addr_q;
    node_rd_d   = 1'b0;
    node_addr_d = node_addr_q;
    next_d      = next_q;
    payload_d   = payload_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          count_d     = '0;
          err_theta_d = 1'b0;
          err_loop_d  = 1'b0;
          if (int'(bus.theta_i) >= THETA_BINS) begin
            err_theta_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            head_rd_d   = 1'b1;
            head_addr_d = bus.theta_i;
            state_d     = S_RD_HEAD;
          end
        end
      end
      S_RD_HEAD: state_d = S_WAIT_HEAD;
      S_WAIT_HEAD: begin
        if (bus.head_data_i == NULL_PTR) begin
          state_d = S_DONE;
        end else begin
          node_rd_d   = 1'b1;
          node_addr_d = bus.head_data_i;
          state_d     = S_RD_NODE;
        end
      end
      S_RD_NODE: state_d = S_WAIT_NODE;
      S_WAIT_NODE: begin
        next_d    = bus.node_data_i[NEXT_MSB:NEXT_LSB];
        payload_d = bus.node_data_i[PAYLOAD_MSB:PAYLOAD_LSB];
        state_d   = S_EMIT;
      end
      S_EMIT: begin
        if (bus.out_ready_i) begin
          count_d = count_q + PTR_W'(1);
          if (last) begin
            err_loop_d = (next_q != NULL_PTR);
            state_d    = S_DONE;
          end else begin
            node_rd_d   = 1'b1;
            node_addr_d = next_q;
            state_d     = S_RD_NODE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      err_theta_q <= 1'b0;
      err_loop_q  <= 1'b0;
      head_rd_q   <= 1'b0;
      head_addr_q <= '0;
      node_rd_q   <= 1'b0;
      node_addr_q <= '0;
      next_q      <= '0;
      payload_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_theta_q <= err_theta_d;
      err_loop_q  <= err_loop_d;
      head_rd_q   <= head_rd_d;
      head_addr_q <= head_addr_d;
      node_rd_q   <= node_rd_d;
      node_addr_q <= node_addr_d;
      next_q      <= next_d;
      payload_q   <= payload_d;
    end
  end

  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.count_o     = count_q;
  assign bus.err_theta_o = err_theta_q;
  assign bus.err_loop_o  = err_loop_q;
  assign bus.head_rd_o   = head_rd_q;
  assign bus.head_addr_o = head_addr_q;
  assign bus.node_rd_o   = node_rd_q;
  assign bus.node_addr_o = node_addr_q;
  assign bus.out_valid_o = (state_q == S_EMIT);
  assign bus.out_data_o  = payload_q;
  assign bus.out_last_o  = (state_q == S_EMIT) && last;

endmodule

// File: tb/tb_hough_list_walker.sv
// Directed bench for hough_list_walker with synchronous memory models
// and a queue of expected payload beats.
module tb_hough_list_walker;
  import hough_pkg::*;

  typedef struct {
    logic [19:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  logic clk;
  logic rst;
  hough_list_walker_if bus();

  hough_list_walker u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [11:0] head_mem [256];
  logic [31:0] node_mem [4096];
  beat_t sb[$];
  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.head_rd_o) bus.head_data_i <= head_mem[bus.head_addr_o];
    if (bus.node_rd_o) bus.node_data_i <= node_mem[bus.node_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_chain(input bit timed);
    beat_t b;
    b.data = 20'h00AAA; b.last = 1'b0; b.cyc = timed ? 5 : -1;
    sb.push_back(b);
    b.data = 20'h00BBB; b.last = 1'b0; b.cyc = timed ? 8 : -1;
    sb.push_back(b);
    b.data = 20'h00CCC; b.last = 1'b1; b.cyc = timed ? 11 : -1;
    sb.push_back(b);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, bus.out_valid_o}, 0);
    chk({tag, "_last"}, {31'b0, bus.out_last_o}, 0);
    chk({tag, "_busy"}, {31'b0, bus.busy_o}, 0);
    chk({tag, "_done"}, {31'b0, bus.done_o}, 0);
    chk({tag, "_count"}, {20'b0, bus.count_o}, 0);
    chk({tag, "_errs"}, {30'b0, bus.err_theta_o, bus.err_loop_o}, 0);
    chk({tag, "_strobes"}, {30'b0, bus.head_rd_o, bus.node_rd_o}, 0);
    chk({tag, "_haddr"}, {24'b0, bus.head_addr_o}, 0);
    chk({tag, "_naddr"}, {20'b0, bus.node_addr_o}, 0);
    chk({tag, "_data"}, {12'b0, bus.out_data_o}, 0);
  endtask

  task automatic walk(input logic [7:0] th, input bit bp,
                      input int exp_done, input int exp_cnt,
                      input bit exp_et, input bit exp_el,
                      input int rst_beat, input int limit);
    int beats = 0;
    int stall = 0;
    bit fin = 0;
    bit holding = 0;
    logic [19:0] held = '0;
    beat_t b;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.theta_i = th;
    bus.out_ready_i = !bp;
    for (int cyc = 1; cyc <= limit && !fin; cyc++) begin
      @(negedge clk);
      bus.start_i = (cyc == 2);
      if (cyc == 2) bus.theta_i = 8'd5;
      if (cyc == 1) chk("err_theta_c1", {31'b0, bus.err_theta_o}, exp_et);
      if (exp_et) chk("no_head_rd", {31'b0, bus.head_rd_o}, 0);
      chk("busy", {31'b0, bus.busy_o}, 1);
      if (bp) begin
        if (bus.out_valid_o && stall < 4) begin
          bus.out_ready_i = 1'b0;
          stall++;
        end else if (bus.out_valid_o) begin
          bus.out_ready_i = 1'b1;
          stall = 0;
        end else begin
          bus.out_ready_i = 1'b0;
        end
      end
      if (bus.out_valid_o) begin
        if (holding) chk("hold_data", {12'b0, bus.out_data_o}, {12'b0, held});
        if (!bus.out_ready_i) begin
          chk("no_rd_stall", {31'b0, bus.node_rd_o}, 0);
          held = bus.out_data_o;
          holding = 1'b1;
        end else begin
          holding = 1'b0;
          chk("beat_expected", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            b = sb.pop_front();
            chk("beat_data", {12'b0, bus.out_data_o}, {12'b0, b.data});
            chk("beat_last", {31'b0, bus.out_last_o}, {31'b0, b.last});
            chk("beat_count", {20'b0, bus.count_o}, beats);
            if (b.cyc >= 0) chk("beat_cycle", cyc, b.cyc);
          end
          beats++;
          if (rst_beat == beats) begin
            rst = 1'b1;
            #1;
            check_reset_outputs("midrst");
            @(negedge clk);
            rst = 1'b0;
            sb.delete();
            fin = 1'b1;
          end
        end
      end
      if (!fin && bus.done_o) begin
        if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
        chk("done_count", {20'b0, bus.count_o}, exp_cnt);
        chk("done_err_theta", {31'b0, bus.err_theta_o}, exp_et);
        chk("done_err_loop", {31'b0, bus.err_loop_o}, exp_el);
        chk("sb_drained", sb.size(), 0);
        bus.start_i = 1'b1;
        bus.theta_i = 8'd10;
        @(negedge clk);
        chk("start_at_done_ignored", {31'b0, bus.busy_o}, 0);
        bus.start_i = 1'b0;
        fin = 1'b1;
      end
    end
    if (!fin) chk("walk_timeout", 0, 1);
    bus.start_i = 1'b0;
    bus.out_ready_i = 1'b1;
    sb.delete();
  endtask

  initial begin
    beat_t b;
    for (int i = 0; i < 256; i++) head_mem[i] = 12'h000;
    for (int i = 0; i < 4096; i++) node_mem[i] = 32'h0;
    head_mem[10] = 12'h001;
    node_mem[1] = {12'h003, 20'h00AAA};
    node_mem[3] = {12'h002, 20'h00BBB};
    node_mem[2] = {12'h000, 20'h00CCC};
    head_mem[0] = 12'h007;
    node_mem[7] = {12'h007, 20'h00777};
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.theta_i = '0;
    bus.out_ready_i = 1'b1;
    bus.head_data_i = '0;
    bus.node_data_i = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    walk(8'd5, 1'b0, 3, 0, 1'b0, 1'b0, 0, 50);
    push_chain(1'b1);
    walk(8'd10, 1'b0, 12, 3, 1'b0, 1'b0, 0, 50);
    push_chain(1'b0);
    walk(8'd10, 1'b1, -1, 3, 1'b0, 1'b0, 0, 200);
    walk(8'd180, 1'b0, 1, 0, 1'b1, 1'b0, 0, 20);
    push_chain(1'b1);
    walk(8'd10, 1'b0, 12, 3, 1'b0, 1'b0, 0, 50);

    for (int i = 0; i < 4095; i++) begin
      b.data = 20'h00777;
      b.last = (i == 4094);
      b.cyc = -1;
      sb.push_back(b);
    end
    walk(8'd0, 1'b0, -1, 4095, 1'b0, 1'b1, 0, 20000);

    push_chain(1'b1);
    walk(8'd10, 1'b0, -1, 3, 1'b0, 1'b0, 2, 50);
    push_chain(1'b1);
    walk(8'd10, 1'b0, 12, 3, 1'b0, 1'b0, 0, 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
